cluster_tcdm_prio_ctrl: RTL and testbench

Run-time priority controller for the cluster heterogeneous TCDM interconnect (HCI). It watches request/grant activity on the core+DMA (log) branch and the HWPE branch, then decides which side gets priority, so neither side starves. It drives the interconnect control inputs (arbitration policy, priority inversion, max low-priority stall) and is programmed through a small peripheral-style register port on the cluster peripheral crossbar.

---
 rtl/cluster_tcdm_prio_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_cluster_tcdm_prio_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_tcdm_prio_ctrl.sv
// cluster_tcdm_prio_ctrl
// Run-time priority controller for the cluster HCI. It watches stall activity
// on the log (core + DMA) branch and the HWPE branch, and flips the HCI
// priority inversion so that the losing side cannot starve. A small
// peripheral-style register port programs the policy and hysteresis.

module cluster_tcdm_prio_ctrl #(
    parameter int NB_CORES  = 8,
    parameter int NB_DMAS   = 4,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_wen_i,
    input  logic [2:0]           cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_r_valid_o,
    output logic [31:0]          cfg_r_rdata_o,
    input  logic [NB_CORES-1:0]  core_req_i,
    input  logic [NB_CORES-1:0]  core_gnt_i,
    input  logic [NB_DMAS-1:0]   dma_req_i,
    input  logic [NB_DMAS-1:0]   dma_gnt_i,
    input  logic                 hwpe_req_i,
    input  logic                 hwpe_gnt_i,
    output logic [1:0]           arb_policy_o,
    output logic                 invert_prio_o,
    output logic [7:0]           low_prio_max_stall_o
);

    // ------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------
    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_MAX_STALL = 3'd1;
    localparam logic [2:0] ADDR_THRESH    = 3'd2;
    localparam logic [2:0] ADDR_WINDOW    = 3'd3;
    localparam logic [2:0] ADDR_STATUS    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_LOG_PRIO  = 2'd1,
        ST_HWPE_PRIO = 2'd2
    } state_e;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 en
    );
        logic [CNT_WIDTH-1:0] result;
        if (en && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [3:0]           ctrl_r;
    logic [7:0]           max_stall_r;
    logic [CNT_WIDTH-1:0] thresh_r;
    logic [CNT_WIDTH-1:0] window_r;

    logic                 wr_en_s;
    logic                 rd_en_s;
    logic [31:0]          rd_data_s;
    logic [31:0]          rdata_nxt_s;
    logic                 r_valid_r;
    logic [31:0]          r_rdata_r;

    logic                 auto_en_s;
    logic                 static_inv_s;
    logic                 log_stall_s;
    logic                 hwpe_stall_s;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [CNT_WIDTH-1:0] log_cnt_r;
    logic [CNT_WIDTH-1:0] log_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] hwpe_cnt_r;
    logic [CNT_WIDTH-1:0] hwpe_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] dwell_r;
    logic [CNT_WIDTH-1:0] dwell_nxt_s;
    logic [15:0]          flips_r;
    logic [15:0]          flips_nxt_s;
    logic                 inv_r;
    logic                 inv_nxt_s;

    logic [CNT_WIDTH-1:0] log_inc_s;
    logic [CNT_WIDTH-1:0] hwpe_inc_s;
    logic [CNT_WIDTH-1:0] dwell_dec_s;
    logic                 switch_ok_s;

    logic [1:0]           arb_policy_r;
    logic [7:0]           max_stall_out_r;

    // Write data bits above the widest field are never stored.
    logic                 unused_wdata_s;

    // ------------------------------------------------------------------
    // Configuration port
    // ------------------------------------------------------------------
    assign cfg_gnt_o      = cfg_req_i;
    assign wr_en_s        = cfg_req_i & ~cfg_wen_i;
    assign rd_en_s        = cfg_req_i &  cfg_wen_i;
    assign unused_wdata_s = ^cfg_wdata_i[31:CNT_WIDTH];

    // Configuration registers, written one edge after the granted request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_r      <= 4'd0;
            max_stall_r <= 8'd8;
            thresh_r    <= CNT_WIDTH'(16);
            window_r    <= CNT_WIDTH'(64);
        end else if (wr_en_s) begin
            case (cfg_addr_i)
                ADDR_CTRL:      ctrl_r      <= cfg_wdata_i[3:0];
                ADDR_MAX_STALL: max_stall_r <= cfg_wdata_i[7:0];
                ADDR_THRESH:    thresh_r    <= cfg_wdata_i[CNT_WIDTH-1:0];
                ADDR_WINDOW:    window_r    <= cfg_wdata_i[CNT_WIDTH-1:0];
                default:        ctrl_r      <= ctrl_r;
            endcase
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Read mux over the current register values; unmapped indices read 0
    always_comb begin
        rd_data_s = 32'd0;
        case (cfg_addr_i)
            ADDR_CTRL:      rd_data_s = {28'd0, ctrl_r};
            ADDR_MAX_STALL: rd_data_s = {24'd0, max_stall_r};
            ADDR_THRESH:    rd_data_s = 32'(thresh_r);
            ADDR_WINDOW:    rd_data_s = 32'(window_r);
            ADDR_STATUS:    rd_data_s = {flips_r, 8'(log_cnt_r), 5'd0, state_r, inv_r};
            default:        rd_data_s = 32'd0;
        endcase
    end

    // Response data: read value for reads, zero for writes and idle cycles
    always_comb begin
        rdata_nxt_s = 32'd0;
        if (rd_en_s) begin
            rdata_nxt_s = rd_data_s;
        end else begin
            rdata_nxt_s = 32'd0;
        end
    end

    // Response channel: one-cycle valid pulse after every granted access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_r <= 1'b0;
            r_rdata_r <= 32'd0;
        end else begin
            r_valid_r <= cfg_req_i;
            r_rdata_r <= rdata_nxt_s;
        end
    end

    assign cfg_r_valid_o = r_valid_r;
    assign cfg_r_rdata_o = r_rdata_r;

    // ------------------------------------------------------------------
    // Stall detection and priority FSM
    // ------------------------------------------------------------------
    assign auto_en_s    = ctrl_r[0];
    assign static_inv_s = ctrl_r[1];

    assign log_stall_s  = (|(core_req_i & ~core_gnt_i)) | (|(dma_req_i & ~dma_gnt_i));
    assign hwpe_stall_s = hwpe_req_i & ~hwpe_gnt_i;

    assign log_inc_s    = sat_inc(log_cnt_r, log_stall_s);
    assign hwpe_inc_s   = sat_inc(hwpe_cnt_r, hwpe_stall_s);
    // A zero threshold freezes the current priority while counters keep running.
    assign switch_ok_s  = (dwell_r == CNT_ZERO) && (thresh_r != CNT_ZERO);

    // Dwell counts down to zero and then holds
    always_comb begin
        dwell_dec_s = dwell_r;
        if (dwell_r != CNT_ZERO) begin
            dwell_dec_s = dwell_r - CNT_ONE;
        end else begin
            dwell_dec_s = CNT_ZERO;
        end
    end

    // Next state, counters and inversion; clearing AUTO_EN beats any switch
    always_comb begin
        state_nxt_s    = state_r;
        log_cnt_nxt_s  = log_cnt_r;
        hwpe_cnt_nxt_s = hwpe_cnt_r;
        dwell_nxt_s    = dwell_r;
        flips_nxt_s    = flips_r;
        inv_nxt_s      = inv_r;
        if (!auto_en_s) begin
            state_nxt_s    = ST_DISABLED;
            log_cnt_nxt_s  = CNT_ZERO;
            hwpe_cnt_nxt_s = CNT_ZERO;
            dwell_nxt_s    = CNT_ZERO;
            inv_nxt_s      = static_inv_s;
        end else begin
            case (state_r)
                ST_DISABLED: begin
                    state_nxt_s    = ST_LOG_PRIO;
                    log_cnt_nxt_s  = CNT_ZERO;
                    hwpe_cnt_nxt_s = CNT_ZERO;
                    dwell_nxt_s    = window_r;
                    inv_nxt_s      = 1'b0;
                end
                ST_LOG_PRIO: begin
                    // Log side has priority: watch the HWPE side starving.
                    if (switch_ok_s && (hwpe_inc_s >= thresh_r)) begin
                        state_nxt_s    = ST_HWPE_PRIO;
                        log_cnt_nxt_s  = CNT_ZERO;
                        hwpe_cnt_nxt_s = CNT_ZERO;
                        dwell_nxt_s    = window_r;
                        flips_nxt_s    = flips_r + 16'd1;
                        inv_nxt_s      = 1'b1;
                    end else begin
                        hwpe_cnt_nxt_s = hwpe_inc_s;
                        dwell_nxt_s    = dwell_dec_s;
                        inv_nxt_s      = 1'b0;
                    end
                end
                ST_HWPE_PRIO: begin
                    // HWPE side has priority: watch the log side starving.
                    if (switch_ok_s && (log_inc_s >= thresh_r)) begin
                        state_nxt_s    = ST_LOG_PRIO;
                        log_cnt_nxt_s  = CNT_ZERO;
                        hwpe_cnt_nxt_s = CNT_ZERO;
                        dwell_nxt_s    = window_r;
                        flips_nxt_s    = flips_r + 16'd1;
                        inv_nxt_s      = 1'b0;
                    end else begin
                        log_cnt_nxt_s  = log_inc_s;
                        dwell_nxt_s    = dwell_dec_s;
                        inv_nxt_s      = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s    = ST_DISABLED;
                    log_cnt_nxt_s  = CNT_ZERO;
                    hwpe_cnt_nxt_s = CNT_ZERO;
                    dwell_nxt_s    = CNT_ZERO;
                    inv_nxt_s      = static_inv_s;
                end
            endcase
        end
    end

    // FSM state, counters and the registered inversion output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_DISABLED;
            log_cnt_r  <= CNT_ZERO;
            hwpe_cnt_r <= CNT_ZERO;
            dwell_r    <= CNT_ZERO;
            flips_r    <= 16'd0;
            inv_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            log_cnt_r  <= log_cnt_nxt_s;
            hwpe_cnt_r <= hwpe_cnt_nxt_s;
            dwell_r    <= dwell_nxt_s;
            flips_r    <= flips_nxt_s;
            inv_r      <= inv_nxt_s;
        end
    end

    // Registered pass-through of policy and max-stall to the interconnect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arb_policy_r    <= 2'd0;
            max_stall_out_r <= 8'd8;
        end else begin
            arb_policy_r    <= ctrl_r[3:2];
            max_stall_out_r <= max_stall_r;
        end
    end

    assign arb_policy_o         = arb_policy_r;
    assign invert_prio_o        = inv_r;
    assign low_prio_max_stall_o = max_stall_out_r;

endmodule

// File: tb/tb_cluster_tcdm_prio_ctrl.sv
// Testbench for cluster_tcdm_prio_ctrl: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a behavioural reference model.

module tb_cluster_tcdm_prio_ctrl;

    localparam int NB_CORES = 8;
    localparam int NB_DMAS  = 4;
    localparam int CMAX     = 1023;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic cfg_req = 1'b0;
    logic cfg_wen = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [NB_CORES-1:0] core_req = '0;
    logic [NB_CORES-1:0] core_gnt = '0;
    logic [NB_DMAS-1:0] dma_req = '0;
    logic [NB_DMAS-1:0] dma_gnt = '0;
    logic hwpe_req = 1'b0;
    logic hwpe_gnt = 1'b0;

    logic cfg_gnt_o;
    logic cfg_r_valid_o;
    logic [31:0] cfg_r_rdata_o;
    logic [1:0] arb_policy_o;
    logic invert_prio_o;
    logic [7:0] low_prio_max_stall_o;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int m_ctrl, m_mstall, m_thresh, m_window;
    int m_mode, m_lcnt, m_hcnt, m_dwell, m_flips, m_inv;
    int m_pol, m_ms, m_rv;
    logic [31:0] m_rd;

    cluster_tcdm_prio_ctrl #(
        .NB_CORES (NB_CORES),
        .NB_DMAS  (NB_DMAS),
        .CNT_WIDTH(10)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cfg_req_i           (cfg_req),
        .cfg_wen_i           (cfg_wen),
        .cfg_addr_i          (cfg_addr),
        .cfg_wdata_i         (cfg_wdata),
        .cfg_gnt_o           (cfg_gnt_o),
        .cfg_r_valid_o       (cfg_r_valid_o),
        .cfg_r_rdata_o       (cfg_r_rdata_o),
        .core_req_i          (core_req),
        .core_gnt_i          (core_gnt),
        .dma_req_i           (dma_req),
        .dma_gnt_i           (dma_gnt),
        .hwpe_req_i          (hwpe_req),
        .hwpe_gnt_i          (hwpe_gnt),
        .arb_policy_o        (arb_policy_o),
        .invert_prio_o       (invert_prio_o),
        .low_prio_max_stall_o(low_prio_max_stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_mstall = 8; m_thresh = 16; m_window = 64;
        m_mode = 0; m_lcnt = 0; m_hcnt = 0; m_dwell = 0; m_flips = 0; m_inv = 0;
        m_pol = 0; m_ms = 8; m_rv = 0; m_rd = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return 32'(m_ctrl);
            1: return 32'(m_mstall);
            2: return 32'(m_thresh);
            3: return 32'(m_window);
            4: return 32'((m_flips << 16) | ((m_lcnt % 256) << 8) | (m_mode << 1) | m_inv);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("invert_prio", 32'(invert_prio_o), 32'(m_inv));
        chk("arb_policy", 32'(arb_policy_o), 32'(m_pol));
        chk("max_stall", 32'(low_prio_max_stall_o), 32'(m_ms));
        chk("r_valid", 32'(cfg_r_valid_o), 32'(m_rv));
        chk("r_rdata", cfg_r_rdata_o, m_rd);
    endtask

    // One clock: predict from the rules, advance the DUT, compare.
    task automatic tick();
        int hs, ls, auto_en, sinv, c;
        int n_mode, n_l, n_h, n_d, n_f, n_inv;
        int n_ctrl, n_mstall, n_thresh, n_window;
        int n_pol, n_ms, n_rv;
        logic [31:0] n_rd;
        chk("cfg_gnt", 32'(cfg_gnt_o), 32'(cfg_req));
        hs = (hwpe_req && !hwpe_gnt) ? 1 : 0;
        ls = 0;
        for (int i = 0; i < NB_CORES; i++) if (core_req[i] && !core_gnt[i]) ls = 1;
        for (int i = 0; i < NB_DMAS; i++) if (dma_req[i] && !dma_gnt[i]) ls = 1;
        n_rv = cfg_req ? 1 : 0;
        n_rd = (cfg_req && cfg_wen) ? m_read(int'(cfg_addr)) : 32'd0;
        n_pol = (m_ctrl >> 2) & 3;
        n_ms = m_mstall;
        auto_en = m_ctrl & 1;
        sinv = (m_ctrl >> 1) & 1;
        n_mode = m_mode; n_l = m_lcnt; n_h = m_hcnt; n_d = m_dwell; n_f = m_flips;
        if (auto_en == 0) begin
            n_mode = 0; n_l = 0; n_h = 0; n_d = 0;
        end else if (m_mode == 0) begin
            n_mode = 1; n_l = 0; n_h = 0; n_d = m_window;
        end else begin
            // the side without priority is the one whose stalls are counted
            c = (m_mode == 1) ? m_hcnt + hs : m_lcnt + ls;
            if (c > CMAX) c = CMAX;
            if (m_dwell == 0 && m_thresh != 0 && c >= m_thresh) begin
                n_mode = 3 - m_mode; n_l = 0; n_h = 0; n_d = m_window;
                n_f = (m_flips + 1) % 65536;
            end else begin
                if (m_mode == 1) n_h = c; else n_l = c;
                if (m_dwell > 0) n_d = m_dwell - 1;
            end
        end
        n_inv = (n_mode == 0) ? sinv : ((n_mode == 2) ? 1 : 0);
        n_ctrl = m_ctrl; n_mstall = m_mstall; n_thresh = m_thresh; n_window = m_window;
        if (cfg_req && !cfg_wen) begin
            case (int'(cfg_addr))
                0: n_ctrl = int'(cfg_wdata & 32'hF);
                1: n_mstall = int'(cfg_wdata & 32'hFF);
                2: n_thresh = int'(cfg_wdata & 32'h3FF);
                3: n_window = int'(cfg_wdata & 32'h3FF);
                default: n_ctrl = m_ctrl;
            endcase
        end
        @(posedge clk_i);
        #1;
        m_mode = n_mode; m_lcnt = n_l; m_hcnt = n_h; m_dwell = n_d; m_flips = n_f; m_inv = n_inv;
        m_ctrl = n_ctrl; m_mstall = n_mstall; m_thresh = n_thresh; m_window = n_window;
        m_pol = n_pol; m_ms = n_ms; m_rv = n_rv; m_rd = n_rd;
        check_outputs();
    endtask

    task automatic cfg_write(input int a, input logic [31:0] d);
        cfg_req = 1'b1; cfg_wen = 1'b0; cfg_addr = 3'(a); cfg_wdata = d;
        tick();
        cfg_req = 1'b0; cfg_wdata = 32'd0;
    endtask

    task automatic cfg_read(input int a, output logic [31:0] d);
        cfg_req = 1'b1; cfg_wen = 1'b1; cfg_addr = 3'(a);
        tick();
        d = cfg_r_rdata_o;
        cfg_req = 1'b0; cfg_wen = 1'b0;
    endtask

    task automatic set_stall(input int l, input int h);
        core_req = (l != 0) ? 8'h10 : 8'h00;
        core_gnt = 8'h00;
        dma_req = 4'h0; dma_gnt = 4'h0;
        hwpe_req = (h != 0); hwpe_gnt = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int a, op, k;
        model_reset();

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_inv", 32'(invert_prio_o), 32'd0);
        chk("reset_policy", 32'(arb_policy_o), 32'd0);
        chk("reset_max_stall", 32'(low_prio_max_stall_o), 32'd8);
        chk("reset_r_valid", 32'(cfg_r_valid_o), 32'd0);
        chk("reset_r_rdata", cfg_r_rdata_o, 32'd0);
        rst_i = 1'b0;
        tick();
        cfg_read(0, d); chk("rd_ctrl_reset", d, 32'd0);
        cfg_read(1, d); chk("rd_max_stall_reset", d, 32'd8);
        cfg_read(2, d); chk("rd_thresh_reset", d, 32'd16);
        cfg_read(3, d); chk("rd_window_reset", d, 32'd64);
        cfg_read(4, d); chk("rd_status_reset", d, 32'd0);
        cfg_read(6, d); chk("rd_unmapped", d, 32'd0);
        cfg_write(5, 32'hFFFF_FFFF);

        // static mode
        cfg_write(0, 32'hE);
        tick();
        chk("static_inv", 32'(invert_prio_o), 32'd1);
        chk("static_policy", 32'(arb_policy_o), 32'd3);
        cfg_read(4, d); chk("static_status", d, 32'h1);

        // HWPE starvation
        cfg_write(2, 32'd4);
        cfg_write(3, 32'd0);
        cfg_write(0, 32'd1);
        tick();
        cfg_read(4, d); chk("auto_log_prio", d, 32'h2);
        set_stall(0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("starve_no_flip_yet", 32'(invert_prio_o), 32'd0);
        end
        tick();
        chk("starve_flip", 32'(invert_prio_o), 32'd1);
        set_stall(0, 0);
        cfg_read(4, d); chk("starve_status", d, 32'h0001_0005);

        // dwell hysteresis
        cfg_write(2, 32'd2);
        cfg_write(3, 32'd10);
        set_stall(1, 0);
        tick(); tick();
        chk("back_to_log", 32'(invert_prio_o), 32'd0);
        set_stall(0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dwell_log_hold", 32'(invert_prio_o), 32'd0);
        end
        tick();
        chk("dwell_log_release", 32'(invert_prio_o), 32'd1);
        set_stall(1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dwell_hwpe_hold", 32'(invert_prio_o), 32'd1);
        end
        tick();
        chk("dwell_hwpe_release", 32'(invert_prio_o), 32'd0);

        // disable mid-run, racing a pending switch
        set_stall(0, 0);
        cfg_write(3, 32'd0);
        set_stall(0, 1);
        for (k = 0; k < 20 && !invert_prio_o; k++) tick();
        chk("wait_hwpe_prio", 32'(invert_prio_o), 32'd1);
        set_stall(1, 0);
        cfg_write(0, 32'd0);
        chk("disable_write_cycle", 32'(invert_prio_o), 32'd1);
        tick();
        chk("disable_inv", 32'(invert_prio_o), 32'd0);
        set_stall(0, 0);
        cfg_read(4, d); chk("disable_status", d, 32'h0005_0000);

        // counter saturation while frozen by THRESH = 0
        cfg_write(2, 32'd1);
        cfg_write(0, 32'd1);
        tick();
        set_stall(0, 1);
        tick();
        set_stall(0, 0);
        cfg_write(2, 32'd0);
        set_stall(1, 0);
        repeat (1100) tick();
        set_stall(0, 0);
        cfg_read(4, d);
        chk("sat_log_cnt", 32'(d[15:8]), 32'hFF);
        chk("sat_state", 32'(d[2:1]), 32'd2);
        cfg_write(2, 32'd5);
        tick();
        chk("unfreeze_flip", 32'(invert_prio_o), 32'd0);

        // randomized traffic and register accesses
        for (int it = 0; it < 1500; it++) begin
            core_req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            core_gnt = 8'($urandom);
            dma_req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            dma_gnt  = 4'($urandom);
            hwpe_req = 1'($urandom);
            hwpe_gnt = 1'($urandom);
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                a = int'($urandom_range(0, 7));
                d = $urandom;
                if (a == 0) d[0] = ($urandom_range(0, 4) != 0);
                if (a == 2 || a == 3) d = (d & 32'hFFFF_FC00) | $urandom_range(0, 8);
                cfg_req = 1'b1; cfg_wen = 1'b0; cfg_addr = 3'(a); cfg_wdata = d;
            end else if (op == 1) begin
                cfg_req = 1'b1; cfg_wen = 1'b1; cfg_addr = 3'($urandom_range(0, 7));
            end else begin
                cfg_req = 1'b0;
            end
            tick();
        end
        cfg_req = 1'b0;

        // asynchronous reset with a switch pending
        set_stall(0, 0);
        cfg_write(0, 32'd0);
        tick();
        cfg_write(3, 32'd0);
        cfg_write(2, 32'd3);
        cfg_write(1, 32'd77);
        cfg_write(0, 32'h5);
        tick();
        set_stall(0, 1);
        tick(); tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_inv", 32'(invert_prio_o), 32'd0);
        chk("arst_policy", 32'(arb_policy_o), 32'd0);
        chk("arst_max_stall", 32'(low_prio_max_stall_o), 32'd8);
        chk("arst_r_valid", 32'(cfg_r_valid_o), 32'd0);
        chk("arst_r_rdata", cfg_r_rdata_o, 32'd0);
        model_reset();
        #1;
        rst_i = 1'b0;
        set_stall(0, 0);
        cfg_read(4, d); chk("arst_status", d, 32'd0);
        cfg_read(2, d); chk("arst_thresh", d, 32'd16);
        cfg_read(1, d); chk("arst_max_stall_reg", d, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
